// File: rtl/axi_arb_pkg.sv
// Shared encodings for the AXI request arbiter: response codes, burst types,
// FSM states and a response-merging helper.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  // Read responses merge as the numerically worst code seen so far.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping around; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int k;
    logic [IDX_W-1:0] kk;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < NREQ; i++) begin
      k  = (int'(ptr_i) + i) % NREQ;
      kk = IDX_W'(k);
      if (en_i && !found && req_i[kk]) begin
        grant_o[kk] = 1'b1;
        idx_o       = kk;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin sharing of one AXI command port among NREQ requesters, one
// outstanding burst at a time, with per-requester completion pulses.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  input  logic [NREQ*3-1:0]      req_size,
  input  logic [NREQ*2-1:0]      req_burst,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_write,
  output logic [ADDR_W-1:0]      cmd_addr,
  output logic [LEN_W-1:0]       cmd_len,
  output logic [2:0]             cmd_size,
  output logic [1:0]             cmd_burst,
  output logic [ID_W-1:0]        cmd_id,
  input  logic                   bvalid,
  input  logic                   bready,
  input  logic [ID_W-1:0]        bid,
  input  logic [1:0]             bresp,
  input  logic                   rvalid,
  input  logic                   rready,
  input  logic                   rlast,
  input  logic [ID_W-1:0]        rid,
  input  logic [1:0]             rresp,
  output logic [NREQ-1:0]        done,
  output logic [1:0]             done_resp,
  output logic                   timeout_err,
  output logic                   id_err,
  output logic [1:0]             dbg_state_o
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT) + 1;
  localparam int BEAT_W = LEN_W + 1;

  state_e              state_q;
  logic [IDX_W-1:0]    ptr_q, gnt_q;
  logic                cmd_valid_q, cmd_write_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [LEN_W-1:0]    cmd_len_q;
  logic [2:0]          cmd_size_q;
  logic [1:0]          cmd_burst_q;
  logic [ID_W-1:0]     cmd_id_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [1:0]          resp_q;
  logic                len_err_q;
  logic [NREQ-1:0]     done_q;
  logic [1:0]          done_resp_q;
  logic                timeout_err_q, id_err_q;

  logic [NREQ-1:0]     win_oh;
  logic [IDX_W-1:0]    win_idx, ptr_nx;
  logic [BEAT_W-1:0]   beat_nx, exp_beats;
  logic                w_match, r_match, id_bad, fin, overrun, tmo_hit;
  logic [1:0]          fin_resp;
  int                  sel;

  // reset gates the arbiter so req_ready stays low while reset is held
  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    ((state_q == ST_IDLE) && !reset),
    .grant_o (win_oh),
    .idx_o   (win_idx)
  );

  always_comb begin
    sel       = int'(win_idx);
    ptr_nx    = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    beat_nx   = beat_q + BEAT_W'(1);
    exp_beats = {1'b0, cmd_len_q} + BEAT_W'(1);
    w_match   = bvalid && bready && (bid == cmd_id_q);
    r_match   = rvalid && rready && (rid == cmd_id_q);
    id_bad    = cmd_write_q ? (bvalid && bready && (bid != cmd_id_q))
                            : (rvalid && rready && (rid != cmd_id_q));
    fin       = cmd_write_q ? w_match : (r_match && rlast);
    overrun   = r_match && !rlast && (beat_nx > exp_beats);
    tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));
    if (cmd_write_q)
      fin_resp = bresp;
    else if (len_err_q || (beat_nx != exp_beats))
      fin_resp = RESP_SLVERR;
    else
      fin_resp = resp_max(resp_q, rresp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      gnt_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      cmd_size_q    <= '0;
      cmd_burst_q   <= '0;
      cmd_id_q      <= '0;
      beat_q        <= '0;
      tmo_q         <= '0;
      resp_q        <= '0;
      len_err_q     <= 1'b0;
      done_q        <= '0;
      done_resp_q   <= '0;
      timeout_err_q <= 1'b0;
      id_err_q      <= 1'b0;
    end else begin
      done_q        <= '0;
      done_resp_q   <= '0;
      timeout_err_q <= 1'b0;
      id_err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|win_oh) begin
            gnt_q       <= win_idx;
            ptr_q       <= ptr_nx;
            cmd_valid_q <= 1'b1;
            cmd_write_q <= req_write[win_idx];
            cmd_addr_q  <= req_addr[sel*ADDR_W +: ADDR_W];
            cmd_len_q   <= req_len[sel*LEN_W +: LEN_W];
            cmd_size_q  <= req_size[sel*3 +: 3];
            cmd_burst_q <= req_burst[sel*2 +: 2];
            cmd_id_q    <= ID_W'(win_idx);
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            beat_q      <= '0;
            tmo_q       <= '0;
            resp_q      <= RESP_OKAY;
            len_err_q   <= 1'b0;
            state_q     <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          tmo_q    <= tmo_q + TMO_W'(1);
          id_err_q <= id_bad;
          if (!cmd_write_q && r_match) begin
            beat_q <= beat_nx;
            resp_q <= resp_max(resp_q, rresp);
            if (overrun) len_err_q <= 1'b1;
          end
          // completion takes priority over a timeout landing on the same cycle
          if (fin) begin
            done_q      <= NREQ'(1) << gnt_q;
            done_resp_q <= fin_resp;
            state_q     <= ST_DONE;
          end else if (tmo_hit) begin
            done_q        <= NREQ'(1) << gnt_q;
            done_resp_q   <= RESP_DECERR;
            timeout_err_q <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = win_oh;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign cmd_size    = cmd_size_q;
  assign cmd_burst   = cmd_burst_q;
  assign cmd_id      = cmd_id_q;
  assign done        = done_q;
  assign done_resp   = done_resp_q;
  assign timeout_err = timeout_err_q;
  assign id_err      = id_err_q;
  assign dbg_state_o = state_q;

endmodule
